mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one data-memory channel between the per-thread LSUs of a core.
- LSUs hand over one load or store each through a valid/ready handshake.
- The arbiter issues exactly one memory transaction at a time on the channel and returns the result to the owning LSU with a one-cycle response pulse.
- It sits between the core's LSU lanes and the device memory controller.

Parameters:
- NUM_REQUESTERS, 4, number of LSU lanes sharing the channel (≥1).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.
- IDX_BITS, max(1,$clog2(NUM_REQUESTERS)), width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQUESTERS  per-lane request pending.
- req_write  input  NUM_REQUESTERS  per-lane: 1=store, 0=load.
- req_addr  input  NUM_REQUESTERS*ADDR_BITS  flattened; lane i at [i*ADDR_BITS +: ADDR_BITS].
- req_wdata  input  NUM_REQUESTERS*DATA_BITS  flattened store data.
- req_ready  output  NUM_REQUESTERS  one-hot accept (combinational).
- resp_valid  output  NUM_REQUESTERS  one-hot completion pulse (registered).
- resp_rdata  output  DATA_BITS  load data; valid only with resp_valid.
- mem_read_valid  output  1  read request to the memory controller.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  read done; mem_read_data valid this cycle.
- mem_read_data  input  DATA_BITS  read data.
- mem_write_valid  output  1  write request.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  write done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - mem_read_valid, mem_write_valid, resp_valid all 0.
  - Addresses, data and resp_rdata all 0.
  - Any in-flight transaction is abandoned; the memory valids drop immediately.
- FSM states: IDLE, READING, WRITING, RESPOND.
- IDLE:
  - Grant = first lane with req_valid=1, scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQUESTERS.
  - req_ready[grant]=1 combinationally, only in IDLE; all other lanes' req_ready=0.
  - On the edge where the grant lane's valid&ready are both 1, latch lane index, write flag, addr and wdata.
  - Next state: WRITING if write, else READING.
  - No req_valid: stay in IDLE.
- READING:
  - mem_read_valid=1; mem_read_address holds the latched address.
  - On the edge with mem_read_ready=1: capture mem_read_data into resp_rdata, drop mem_read_valid, go to RESPOND.
- WRITING: same as READING using the mem_write_* signals.
  - On mem_write_ready=1, go to RESPOND; resp_rdata unchanged.
- RESPOND (exactly 1 cycle):
  - resp_valid[latched idx]=1, all other bits 0.
  - rr_ptr <= (idx+1) wrapping to 0 after NUM_REQUESTERS-1.
  - Next state: IDLE.
- Latency:
  - Accept edge E0, then memory valid high from cycle E0+1.
  - With a same-cycle ready at edge E1, resp_valid is high in the cycle after E1.
  - Minimum 3 cycles from accept to the return to IDLE.
- Boundary conditions:
  - mem_*_ready while the corresponding valid is 0 is ignored.
  - Both readies high during READING: only mem_read_ready counts.
  - A lane may withdraw req_valid before it is granted; no grant results.
  - req_valid held after acceptance is treated as a new request at the next IDLE.
  - req_* inputs are not sampled outside the accept edge.
  - NUM_REQUESTERS=1: rr_ptr stays 0.
  - At most one transaction is outstanding; there are no queues.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Extra output stall_cycles [15:0], reset to 0.
  - Increments each cycle where |req_valid=1 and no request is accepted that cycle.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single load: lane 2 req addr 8'h10, memory returns 8'hAB one cycle later -> mem_read_address=8'h10; resp_valid=4'b0100 for one cycle; resp_rdata=8'hAB.
- Single store: lane 0 writes 8'h5A to 8'h20, mem_write_ready after 3 cycles -> mem_write_valid held 3 cycles; resp_valid=4'b0001 one cycle.
- Fairness: all 4 lanes hold loads from reset -> grant order 0,1,2,3,0; no lane is granted twice before all others have been served.
- Wrap: rr_ptr=3, lanes 1 and 3 valid -> lane 3 first, then lane 1.
- Reset mid-op: reset=0 during READING with mem_read_ready=0 -> mem_read_valid drops without a clock; no resp_valid; after release the first grant goes to lane 0.
- Perf (MEM_ARB_PERF_EN): 2 lanes contend for 10 cycles with 1-cycle memory -> stall_cycles matches a model count; forced 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - LSU request/response and memory channel bundle for mem_arbiter
// Signals: req_valid/req_write/req_addr/req_wdata/req_ready per LSU lane (flattened),
//          resp_valid/resp_rdata back to the lanes,
//          mem_read_* and mem_write_* toward the memory controller.
// Modports: master = arbiter side, slave = LSU lanes plus memory controller side.
interface mem_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8
);
    logic [NUM_REQUESTERS-1:0]           req_valid;
    logic [NUM_REQUESTERS-1:0]           req_write;
    logic [NUM_REQUESTERS*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQUESTERS*DATA_BITS-1:0] req_wdata;
    logic [NUM_REQUESTERS-1:0]           req_ready;
    logic [NUM_REQUESTERS-1:0]           resp_valid;
    logic [DATA_BITS-1:0]                resp_rdata;

    logic                                mem_read_valid;
    logic [ADDR_BITS-1:0]                mem_read_address;
    logic                                mem_read_ready;
    logic [DATA_BITS-1:0]                mem_read_data;
    logic                                mem_write_valid;
    logic [ADDR_BITS-1:0]                mem_write_address;
    logic [DATA_BITS-1:0]                mem_write_data;
    logic                                mem_write_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output req_ready, resp_valid, resp_rdata,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data-memory channel among LSU lanes
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          mem_arbiter_if.master: per-lane req/resp handshake and memory read/write channel
//   stall_cycles [15:0] saturating count of cycles with a pending request but no accept
//                (present only when MEM_ARB_PERF_EN is defined)
// One transaction is in flight at a time: IDLE -> READING/WRITING -> RESPOND -> IDLE.
module mem_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int IDX_BITS       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]   stall_cycles
`endif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READING = 2'd1,
        WRITING = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [IDX_BITS-1:0]       rr_ptr;
    logic [IDX_BITS-1:0]       cur_idx;
    logic [IDX_BITS-1:0]       grant_idx;
    logic                      grant_found;
    logic                      accept;
    logic [ADDR_BITS-1:0]      cur_addr;
    logic [DATA_BITS-1:0]      cur_wdata;
    logic [DATA_BITS-1:0]      rdata_q;
    logic [NUM_REQUESTERS-1:0] resp_q;

    // Scan lanes starting at rr_ptr; first valid lane wins.
    always_comb begin
        int                  lane;
        logic [IDX_BITS-1:0] lane_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        lane        = 0;
        lane_idx    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            lane = int'(rr_ptr) + k;
            if (lane >= NUM_REQUESTERS) begin
                lane = lane - NUM_REQUESTERS;
            end
            lane_idx = IDX_BITS'(lane);
            if (!grant_found && bus.req_valid[lane_idx]) begin
                grant_found = 1'b1;
                grant_idx   = lane_idx;
            end
        end
    end

    assign accept = (state == IDLE) && grant_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Only the ready that matches the current direction can advance the FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = bus.req_write[grant_idx] ? WRITING : READING;
                end
            end
            READING: begin
                if (bus.mem_read_ready) begin
                    state_next = RESPOND;
                end
            end
            WRITING: begin
                if (bus.mem_write_ready) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            cur_idx   <= '0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            if (accept) begin
                cur_idx   <= grant_idx;
                cur_addr  <= bus.req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
                cur_wdata <= bus.req_wdata[int'(grant_idx)*DATA_BITS +: DATA_BITS];
            end
            if (state == READING && bus.mem_read_ready) begin
                rdata_q <= bus.mem_read_data;
            end
            // Pulse is registered so it lines up with the RESPOND cycle.
            resp_q <= '0;
            if (state_next == RESPOND) begin
                resp_q[cur_idx] <= 1'b1;
            end
            // Next scan starts just past the lane that was served.
            if (state == RESPOND) begin
                rr_ptr <= (cur_idx == IDX_BITS'(NUM_REQUESTERS - 1)) ? '0 : cur_idx + 1'b1;
            end
        end
    end

    // Valids decode straight from state so an async reset drops them at once.
    assign bus.mem_read_valid    = (state == READING);
    assign bus.mem_write_valid   = (state == WRITING);
    assign bus.mem_read_address  = cur_addr;
    assign bus.mem_write_address = cur_addr;
    assign bus.mem_write_data    = cur_wdata;
    assign bus.resp_valid        = resp_q;
    assign bus.resp_rdata        = rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((|bus.req_valid) && !accept && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk;
    logic reset;

    mem_arbiter_if #(.NUM_REQUESTERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [15:0] stall_cycles;
`endif

    mem_arbiter #(.NUM_REQUESTERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: pending transaction, rr pointer, held read data.
    int          m_phase;  // 0 waiting for grant, 1 memory access, 2 response cycle
    int          m_rr;
    int          m_lane;
    bit          m_write;
    logic [7:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    int          m_stall;
    int          grants[$];

    logic [3:0]  obs_ready, obs_resp;
    logic        obs_rv, obs_wv;
    logic [7:0]  obs_raddr, obs_waddr, obs_wdata, obs_rdata;

    typedef struct {
        int         lane;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
        logic [3:0] exp_resp;
        logic [7:0] exp_rdata;
    } txn_t;

    txn_t tbl[4];
    int   fair_exp[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rr    = 0;
        m_lane  = 0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_stall = 0;
    endtask

    // Called just after a negedge with inputs set: compare, advance model, move to next negedge.
    task automatic cycle();
        logic [3:0] exp_ready;
        logic [3:0] exp_resp;
        int         g;
        int         lane;
        #1;
        g = -1;
        exp_ready = '0;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                lane = (m_rr + k) % N;
                if (g < 0 && bus.req_valid[lane]) g = lane;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        exp_resp = '0;
        if (m_phase == 2) exp_resp[m_lane] = 1'b1;

        chk("req_ready", bus.req_ready, exp_ready);
        chk("mem_read_valid", bus.mem_read_valid, (m_phase == 1 && !m_write));
        chk("mem_write_valid", bus.mem_write_valid, (m_phase == 1 && m_write));
        if (m_phase == 1 && !m_write) chk("mem_read_address", bus.mem_read_address, m_addr);
        if (m_phase == 1 && m_write) begin
            chk("mem_write_address", bus.mem_write_address, m_addr);
            chk("mem_write_data", bus.mem_write_data, m_wdata);
        end
        chk("resp_valid", bus.resp_valid, exp_resp);
        chk("resp_rdata", bus.resp_rdata, m_rdata);
`ifdef MEM_ARB_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
        obs_ready = bus.req_ready;
        obs_resp  = bus.resp_valid;
        obs_rv    = bus.mem_read_valid;
        obs_wv    = bus.mem_write_valid;
        obs_raddr = bus.mem_read_address;
        obs_waddr = bus.mem_write_address;
        obs_wdata = bus.mem_write_data;
        obs_rdata = bus.resp_rdata;

        if ((|bus.req_valid) && g < 0 && m_stall < 16'hFFFF) m_stall++;
        if (m_phase == 0) begin
            if (g >= 0) begin
                m_lane  = g;
                m_write = bus.req_write[g];
                m_addr  = bus.req_addr[g*AW +: AW];
                m_wdata = bus.req_wdata[g*DW +: DW];
                m_phase = 1;
                grants.push_back(g);
            end
        end else if (m_phase == 1) begin
            if (!m_write && bus.mem_read_ready) begin
                m_rdata = bus.mem_read_data;
                m_phase = 2;
            end else if (m_write && bus.mem_write_ready) begin
                m_phase = 2;
            end
        end else begin
            m_rr    = (m_lane + 1) % N;
            m_phase = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        bus.req_valid       = '0;
        bus.mem_read_ready  = 1'b1;
        bus.mem_write_ready = 1'b1;
        for (int c = 0; c < n; c++) cycle();
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
    endtask

    task automatic run_txn(input txn_t t);
        int         vcnt;
        bit         done;
        logic [7:0] seen_addr;
        logic [7:0] seen_wdata;
        logic [3:0] lane_hot;
        vcnt = 0;
        done = 1'b0;
        seen_addr  = '0;
        seen_wdata = '0;
        lane_hot = '0;
        lane_hot[t.lane] = 1'b1;
        bus.req_valid = lane_hot;
        bus.req_write = t.wr ? lane_hot : 4'b0000;
        bus.req_addr[t.lane*AW +: AW]  = t.addr;
        bus.req_wdata[t.lane*DW +: DW] = t.wdata;
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        cycle();
        chk("txn_accept", obs_ready, lane_hot);
        bus.req_valid = '0;
        for (int c = 0; c < 30 && !done; c++) begin
            bus.mem_read_data   = t.rdata;
            // Both readies together: the unrelated one must be ignored.
            bus.mem_read_ready  = (vcnt == t.lat - 1);
            bus.mem_write_ready = (vcnt == t.lat - 1);
            cycle();
            if (obs_rv || obs_wv) begin
                vcnt++;
                seen_addr  = t.wr ? obs_waddr : obs_raddr;
                seen_wdata = obs_wdata;
            end
            if (obs_resp != 4'b0000) begin
                done = 1'b1;
                chk("txn_resp_valid", obs_resp, t.exp_resp);
                chk("txn_resp_rdata", obs_rdata, t.exp_rdata);
            end
        end
        chk("txn_done_in_time", done, 1'b1);
        chk("txn_valid_cycles", vcnt, t.lat);
        chk("txn_address", seen_addr, t.addr);
        if (t.wr) chk("txn_wdata", seen_wdata, t.wdata);
        bus.mem_read_ready  = 1'b0;
        bus.mem_write_ready = 1'b0;
        cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 1'b1, 8'h20, 8'h5A, 8'h00, 3, 4'b0001, 8'h11};
        tbl[1] = '{3, 1'b0, 8'h7F, 8'h00, 8'h3C, 2, 4'b1000, 8'h3C};
        tbl[2] = '{1, 1'b1, 8'hFF, 8'h00, 8'h99, 1, 4'b0010, 8'h3C};
        tbl[3] = '{2, 1'b0, 8'h10, 8'h00, 8'hAB, 1, 4'b0100, 8'hAB};
        fair_exp = '{0, 1, 2, 3, 0};

        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_read_ready  = 1'b0;
        bus.mem_read_data   = '0;
        bus.mem_write_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_read_valid", bus.mem_read_valid, 1'b0);
        chk("rst_mem_write_valid", bus.mem_write_valid, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 4'b0000);
        chk("rst_resp_rdata", bus.resp_rdata, 8'h00);
        chk("rst_read_addr", bus.mem_read_address, 8'h00);
        chk("rst_write_addr", bus.mem_write_address, 8'h00);
        chk("rst_write_data", bus.mem_write_data, 8'h00);
        chk("rst_req_ready", bus.req_ready, 4'b0000);
`ifdef MEM_ARB_PERF_EN
        chk("rst_stall", stall_cycles, 16'h0000);
`endif
        reset = 1'b1;

        // Fairness: every lane holds a load; 1-cycle memory.
        bus.req_valid = 4'hF;
        bus.req_write = 4'h0;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'h11;
        grants.delete();
        for (int c = 0; c < 60 && grants.size() < 5; c++) cycle();
        chk("fair_grant_count", grants.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) chk("fair_order", grants[i], fair_exp[i]);
        end
        drain(4);

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Wrap: pointer now at 3, lanes 1 and 3 contend.
        bus.req_valid = 4'b1010;
        bus.req_write = 4'b0000;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 8'h42;
        grants.delete();
        for (int c = 0; c < 30 && grants.size() < 2; c++) cycle();
        chk("wrap_grant_count", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("wrap_first", grants[0], 3);
            chk("wrap_second", grants[1], 1);
        end
        drain(4);

        // Reset during READING with memory stalled.
        bus.req_valid = 4'b0010;
        bus.req_write = 4'b0000;
        bus.req_addr[1*AW +: AW] = 8'hC3;
        bus.mem_read_ready = 1'b0;
        cycle();
        bus.req_valid = '0;
        cycle();
        chk("midop_reading", obs_rv, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("midop_read_valid_drop", bus.mem_read_valid, 1'b0);
        chk("midop_resp_valid", bus.resp_valid, 4'b0000);
        chk("midop_read_addr", bus.mem_read_address, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 4'hF;
        grants.delete();
        cycle();
        chk("midop_regrant_count", grants.size(), 1);
        if (grants.size() >= 1) chk("midop_first_grant", grants[0], 0);
        chk("midop_first_ready", obs_ready, 4'b0001);
        drain(4);

        // Randomized traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            bus.req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            bus.req_write = 4'($urandom);
            bus.req_addr  = 32'($urandom);
            bus.req_wdata = 32'($urandom);
            bus.mem_read_ready  = ($urandom_range(0, 2) == 0);
            bus.mem_write_ready = ($urandom_range(0, 2) == 0);
            bus.mem_read_data   = 8'($urandom);
            cycle();
        end
        drain(4);

`ifdef MEM_ARB_PERF_EN
        // Two lanes contend with 1-cycle memory; counter tracked by the reference each cycle.
        bus.req_valid = 4'b0011;
        bus.req_write = 4'b0000;
        bus.mem_read_ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        drain(4);
        // Memory never answers while a lane keeps requesting: counter must saturate.
        bus.req_valid = 4'b0001;
        bus.mem_read_ready = 1'b0;
        for (int c = 0; c < 70000; c++) cycle();
        chk("stall_saturated", stall_cycles, 16'hFFFF);
        drain(4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
